// File: rtl/rx_port_cpl_router.sv
// Completion router: tracks four outstanding read tags and steers completion
// words to the main, sg_rx or sg_tx consumer, signalling per-destination done/error.
module rx_port_cpl_router #(
   parameter int C_DATA_WIDTH = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    RX_REQ_ACK,
   input  logic [1:0]              RX_REQ_TAG,
   input  logic [9:0]              RX_REQ_LEN,
   input  logic [1:0]              RX_REQ_SRC,
   input  logic [C_DATA_WIDTH-1:0] CPL_DATA,
   input  logic                    CPL_DATA_VALID,
   input  logic [1:0]              CPL_TAG,
   input  logic                    CPL_ERR,
   output logic [3:0]              TAG_FREE,
   output logic [C_DATA_WIDTH-1:0] MAIN_DATA,
   output logic [C_DATA_WIDTH-1:0] SG_RX_DATA,
   output logic [C_DATA_WIDTH-1:0] SG_TX_DATA,
   output logic                    MAIN_DATA_EN,
   output logic                    SG_RX_DATA_EN,
   output logic                    SG_TX_DATA_EN,
   output logic                    MAIN_DONE,
   output logic                    SG_RX_DONE,
   output logic                    SG_TX_DONE,
   output logic                    MAIN_ERR,
   output logic                    SG_RX_ERR,
   output logic                    SG_TX_ERR,
   output logic                    UNEXP_CPL,
   output logic                    REQ_COLLISION
);

   localparam int NTAG  = 4;
   localparam int NDEST = 3;

   logic [NTAG-1:0]         busy;
   logic [1:0]              src_tab [NTAG];
   logic [10:0]             rem_tab [NTAG];
   logic [2:0]              cnt [NDEST];
   logic [NDEST-1:0]        sticky;

   logic [C_DATA_WIDTH-1:0] data_q [NDEST];
   logic [NDEST-1:0]        data_en_q;
   logic [NDEST-1:0]        done_q;
   logic [NDEST-1:0]        err_q;
   logic                    unexp_q;
   logic                    coll_q;

   logic                    cpl_busy;
   logic [1:0]              cpl_src;
   logic                    beat;
   logic                    err_cpl;
   logic                    retire;
   logic                    unexp;
   logic                    alloc;
   logic                    collide;
   logic [10:0]             new_len;
   logic [NDEST-1:0]        inc;
   logic [NDEST-1:0]        dec;
   logic [NDEST-1:0]        set_err;
   logic [NDEST-1:0]        route;
   logic [NDEST-1:0]        dest_done;
   logic [2:0]              cnt_next [NDEST];

   // A tag retiring this cycle may be reallocated at once; the beat still
   // routes to the old source because cpl_src reads the pre-update table.
   always_comb begin
      cpl_busy = busy[CPL_TAG];
      cpl_src  = src_tab[CPL_TAG];
      err_cpl  = CPL_ERR && cpl_busy;
      beat     = CPL_DATA_VALID && !CPL_ERR && cpl_busy;
      retire   = err_cpl || (beat && (rem_tab[CPL_TAG] == 11'd1));
      unexp    = (CPL_DATA_VALID || CPL_ERR) && !cpl_busy;
      alloc    = RX_REQ_ACK && (RX_REQ_SRC != 2'd3) &&
                 (!busy[RX_REQ_TAG] || (retire && (CPL_TAG == RX_REQ_TAG)));
      collide  = RX_REQ_ACK && !alloc;
      new_len  = (RX_REQ_LEN == 10'd0) ? 11'd1024 : {1'b0, RX_REQ_LEN};
      for (int d = 0; d < NDEST; d++) begin
         inc[d]       = alloc && (RX_REQ_SRC == 2'(d));
         dec[d]       = retire && (cpl_src == 2'(d));
         set_err[d]   = err_cpl && (cpl_src == 2'(d));
         route[d]     = beat && (cpl_src == 2'(d));
         cnt_next[d]  = cnt[d] + {2'b00, inc[d]} - {2'b00, dec[d]};
         dest_done[d] = dec[d] && (cnt_next[d] == 3'd0);
      end
   end

   // Allocation wins over retirement when both target the same entry.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         busy <= '0;
         for (int t = 0; t < NTAG; t++) begin
            src_tab[t] <= 2'd0;
            rem_tab[t] <= 11'd0;
         end
      end else begin
         for (int t = 0; t < NTAG; t++) begin
            if (alloc && (RX_REQ_TAG == 2'(t))) begin
               busy[t]    <= 1'b1;
               src_tab[t] <= RX_REQ_SRC;
               rem_tab[t] <= new_len;
            end else if (retire && (CPL_TAG == 2'(t))) begin
               busy[t]    <= 1'b0;
               rem_tab[t] <= 11'd0;
            end else if (beat && (CPL_TAG == 2'(t))) begin
               rem_tab[t] <= rem_tab[t] - 11'd1;
            end
         end
      end
   end

   // The sticky error is reported with the final done and then forgotten.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sticky <= '0;
         err_q  <= '0;
         done_q <= '0;
         for (int d = 0; d < NDEST; d++) begin
            cnt[d] <= 3'd0;
         end
      end else begin
         for (int d = 0; d < NDEST; d++) begin
            cnt[d]    <= cnt_next[d];
            done_q[d] <= dest_done[d];
            err_q[d]  <= dest_done[d] && (sticky[d] || set_err[d]);
            sticky[d] <= dest_done[d] ? 1'b0 : (sticky[d] || set_err[d]);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_en_q <= '0;
         unexp_q   <= 1'b0;
         coll_q    <= 1'b0;
         for (int d = 0; d < NDEST; d++) begin
            data_q[d] <= '0;
         end
      end else begin
         data_en_q <= route;
         unexp_q   <= unexp;
         coll_q    <= collide;
         for (int d = 0; d < NDEST; d++) begin
            if (route[d]) begin
               data_q[d] <= CPL_DATA;
            end
         end
      end
   end

   assign TAG_FREE      = ~busy;
   assign MAIN_DATA     = data_q[0];
   assign SG_RX_DATA    = data_q[1];
   assign SG_TX_DATA    = data_q[2];
   assign MAIN_DATA_EN  = data_en_q[0];
   assign SG_RX_DATA_EN = data_en_q[1];
   assign SG_TX_DATA_EN = data_en_q[2];
   assign MAIN_DONE     = done_q[0];
   assign SG_RX_DONE    = done_q[1];
   assign SG_TX_DONE    = done_q[2];
   assign MAIN_ERR      = err_q[0];
   assign SG_RX_ERR     = err_q[1];
   assign SG_TX_ERR     = err_q[2];
   assign UNEXP_CPL     = unexp_q;
   assign REQ_COLLISION = coll_q;

endmodule
